// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Radix-2 sequential shift-add multiplier, WIDTH cycles per op,
//               valid/ready handshake on both operand and product sides.
//               Optional macro SEQ_MULTIPLIER_SIGNED_EN adds a signed_mode
//               input selecting two's-complement multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_PW-1:0]     r_a;        // multiplicand, pre-extended to product width
    logic [WIDTH-1:0]    r_b;
    logic [c_PW-1:0]     r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PW-1:0]     r_product;
    logic                r_out_valid;
    logic                r_busy;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic                r_signed;
`endif

    logic                w_accept;
    logic [c_PW-1:0]     w_a_ext;
    logic [c_PW-1:0]     w_term;
    logic [c_PW-1:0]     w_acc_next;

    // A finished product can be consumed and a new operand pair taken on the same edge
    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    assign w_a_ext = {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
`else
    assign w_a_ext = {{WIDTH{1'b0}}, a};
`endif

    // One shift-add step; in signed mode the MSB of b carries negative weight
    always_comb begin
        w_term     = r_b[r_cnt] ? (r_a << r_cnt) : '0;
        w_acc_next = r_acc + w_term;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        if (r_signed && (r_cnt == c_LAST)) begin
            w_acc_next = r_acc - w_term;
        end
`endif
    end

    // Control FSM, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            r_signed    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state     <= S_DONE;
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_product   <= '0;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_product   <= '0;
                    r_busy      <= 1'b0;
                end
            endcase

            // Acceptance overrides the state chosen above (IDLE or DONE->RUN)
            if (w_accept) begin
                r_state <= S_RUN;
                r_a     <= w_a_ext;
                r_b     <= b;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
                r_signed <= signed_mode;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier (WIDTH=8). Expected
//               products are queued on operand acceptance and compared when
//               the DUT hands a product over. Signed cases are built only
//               when SEQ_MULTIPLIER_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*WIDTH-1:0] sb[$];

    seq_multiplier #(.WIDTH(WIDTH)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: extend both operands to product width, multiply modulo 2^(2W)
    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] ma,
                                                 input logic [WIDTH-1:0] mb,
                                                 input logic sm);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = {{WIDTH{sm & ma[WIDTH-1]}}, ma};
        eb = {{WIDTH{sm & mb[WIDTH-1]}}, mb};
        return ea * eb;
    endfunction

    // Scoreboard consumer plus "product is zero when not valid" check
    always @(negedge clk) begin
        logic [2*WIDTH-1:0] exp_p;
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_out", 32'(out_valid), 32'd0);
                    end else begin
                        exp_p = sb.pop_front();
                        check_eq("product", 32'(product), 32'(exp_p));
                    end
                end
            end else begin
                check_eq("invalid_product_zero", 32'(product), 32'd0);
            end
        end
    end

    // Present operands, wait (bounded) for acceptance, queue the expected product
    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic sm);
        int guard;
        logic sm_eff;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        sm_eff = sm;
`else
        sm_eff = 1'b0;
`endif
        a           = ta;
        b           = tb_v;
        signed_mode = sm_eff;
        in_valid    = 1'b1;
        guard       = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        sb.push_back(model(ta, tb_v, sm_eff));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; counts edges until out_valid rises
    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && cyc < 40) begin
            check_eq({tag, "_busy_run"}, 32'(busy), 32'd1);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd8);
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] va [4] = '{8'd15, 8'd255, 8'd0,   8'd1};
        logic [WIDTH-1:0] vb [4] = '{8'd15, 8'd255, 8'd200, 8'd255};

        rst_n       = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_product",   32'(product),   32'd0);
        check_eq("rst_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1;

        // Basic unsigned ops, including the extremes, with one-cycle pulse
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], 1'b0);
            wait_done("basic");
            @(negedge clk);
            check_eq("basic_pulse", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Consumer stalls for 5 cycles; operands presented meanwhile are ignored
        out_ready = 1'b0;
        start_op(8'd12, 8'd10, 1'b0);
        a        = 8'd55;
        b        = 8'd55;
        in_valid = 1'b1;
        wait_done("hold");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check_eq("hold_valid",    32'(out_valid), 32'd1);
            check_eq("hold_product",  32'(product),   32'd120);
            check_eq("hold_in_ready", 32'(in_ready),  32'd0);
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check_eq("hold_cleared_valid", 32'(out_valid), 32'd0);
        check_eq("hold_cleared_busy",  32'(busy),      32'd0);
        @(posedge clk);
        #1;

        // Back-to-back: consume result and accept new operands on one edge
        out_ready = 1'b0;
        start_op(8'd9, 8'd9, 1'b0);
        wait_done("b2b_first");
        @(posedge clk);
        #1;
        a         = 8'd3;
        b         = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(model(8'd3, 8'd7, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("b2b_second");
        @(negedge clk);
        check_eq("b2b_pulse", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset during step 4 discards the operation
        start_op(8'd100, 8'd100, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_product",   32'(product),   32'd0);
        check_eq("mid_rst_busy",      32'(busy),      32'd0);
        check_eq("mid_rst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (12) begin
            @(negedge clk);
            check_eq("post_rst_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
        // Two's-complement build
        start_op(8'h80, 8'h80, 1'b1);
        wait_done("signed_min");
        check_eq("signed_min_val", 32'(product), 32'h4000);
        @(posedge clk);
        #1;
        start_op(8'hFF, 8'h01, 1'b1);
        wait_done("signed_neg1");
        check_eq("signed_neg1_val", 32'(product), 32'hFFFF);
        @(posedge clk);
        #1;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done("unsigned_ff");
        check_eq("unsigned_ff_val", 32'(product), 32'h00FF);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
